// File: rtl/baud_gen_frac_if.sv
// Control/status bundle between a UART datapath and its fractional baud-tick generator.
interface baud_gen_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OS_W   = 4
);
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_wr;
    logic              bit_sync;
    logic              sample_tick;
    logic              bit_tick;
    logic              mid_tick;
    logic [OS_W-1:0]   os_phase;
    logic              cfg_pend;
    logic              cfg_err;

    modport master (
        output en, div_int, div_frac, div_wr, bit_sync,
        input  sample_tick, bit_tick, mid_tick, os_phase, cfg_pend, cfg_err
    );

    modport slave (
        input  en, div_int, div_frac, div_wr, bit_sync,
        output sample_tick, bit_tick, mid_tick, os_phase, cfg_pend, cfg_err
    );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional baud-tick generator: sample, bit and mid-bit ticks from a runtime-writable divisor.
// Define BAUD_FRAC_EN to include the fractional phase accumulator (integer-only periods otherwise).
module baud_gen_frac #(
    parameter int CLK_HZ       = 50000000,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_BAUD = 19200,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4
) (
    input  logic           sys_clk,
    input  logic           rst,
    baud_gen_frac_if.slave bus
);
    localparam int     OS_W     = $clog2(OVERSAMPLE);
    localparam longint BIT_CLKS = longint'(OVERSAMPLE) * longint'(DEFAULT_BAUD);

    function automatic logic [DIV_W-1:0] sat_div(input longint v);
        longint max_v;
        max_v = (longint'(1) << DIV_W) - 1;
        if (v > max_v) return DIV_W'(max_v);
        if (v < 2) return DIV_W'(2);
        return DIV_W'(v);
    endfunction

    localparam logic [DIV_W-1:0] RST_DIV = sat_div(longint'(CLK_HZ) / BIT_CLKS);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] shadow_div;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] period_m1_p0;
    logic [OS_W-1:0]  os_cnt;
    logic             cfg_pend_q;
    logic             cfg_err_p1;
    logic             sample_tick_p1;
    logic             bit_tick_p1;
    logic             mid_tick_p1;
    logic             carry_p0;
    logic             term_p0;
    logic             wr_ok;
    logic             wr_bad;
    logic             apply_now;

    assign wr_ok  = bus.div_wr && (bus.div_int >= DIV_W'(2));
    assign wr_bad = bus.div_wr && (bus.div_int <  DIV_W'(2));

    // Stage p0: current period length and terminal-count decision.
    // A coincident bit_sync wins over the terminal count, so no tick is emitted.
    assign period_m1_p0 = div_reg - DIV_W'(1) + DIV_W'(carry_p0);
    assign term_p0      = bus.en && !bus.bit_sync && (cnt == period_m1_p0);
    assign apply_now    = !bus.en || bus.bit_sync || term_p0;

`ifdef BAUD_FRAC_EN
    function automatic logic [FRAC_W-1:0] round_frac(input longint rem, input longint den);
        longint q;
        longint max_q;
        max_q = (longint'(1) << FRAC_W) - 1;
        q = ((rem << FRAC_W) + den / 2) / den;
        if (q > max_q) q = max_q;
        return FRAC_W'(q);
    endfunction

    localparam logic [FRAC_W-1:0] RST_FRAC = round_frac(longint'(CLK_HZ) % BIT_CLKS, BIT_CLKS);

    logic [FRAC_W-1:0] frac_reg;
    logic [FRAC_W-1:0] shadow_frac;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum_p0;

    // The accumulator overflow stretches the current period by one cycle.
    assign acc_sum_p0 = {1'b0, acc} + {1'b0, frac_reg};
    assign carry_p0   = acc_sum_p0[FRAC_W];

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            frac_reg    <= RST_FRAC;
            shadow_frac <= RST_FRAC;
            acc         <= '0;
        end else begin
            if (!bus.en || bus.bit_sync) begin
                acc <= '0;
            end else if (term_p0) begin
                acc <= acc_sum_p0[FRAC_W-1:0];
            end
            if (apply_now) begin
                if (wr_ok) begin
                    frac_reg <= bus.div_frac;
                end else if (cfg_pend_q) begin
                    frac_reg <= shadow_frac;
                end
            end else if (wr_ok) begin
                shadow_frac <= bus.div_frac;
            end
        end
    end
`else
    logic unused_div_frac;
    assign carry_p0        = 1'b0;
    assign unused_div_frac = ^bus.div_frac;
`endif

    // Stage p1: registered ticks, counters and divisor bookkeeping.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            div_reg        <= RST_DIV;
            shadow_div     <= RST_DIV;
            cfg_pend_q     <= 1'b0;
            cfg_err_p1     <= 1'b0;
            cnt            <= '0;
            os_cnt         <= '0;
            sample_tick_p1 <= 1'b0;
            bit_tick_p1    <= 1'b0;
            mid_tick_p1    <= 1'b0;
        end else begin
            cfg_err_p1     <= wr_bad;
            sample_tick_p1 <= term_p0;
            bit_tick_p1    <= term_p0 && (os_cnt == OS_LAST);
            mid_tick_p1    <= term_p0 && (os_cnt == OS_MID);

            if (!bus.en || bus.bit_sync) begin
                cnt    <= '0;
                os_cnt <= '0;
            end else if (term_p0) begin
                cnt    <= '0;
                os_cnt <= os_cnt + OS_W'(1);
            end else begin
                cnt <= cnt + DIV_W'(1);
            end

            // A write landing on an apply point bypasses the shadow entirely.
            if (apply_now) begin
                if (wr_ok) begin
                    div_reg <= bus.div_int;
                end else if (cfg_pend_q) begin
                    div_reg <= shadow_div;
                end
                cfg_pend_q <= 1'b0;
            end else if (wr_ok) begin
                shadow_div <= bus.div_int;
                cfg_pend_q <= 1'b1;
            end
        end
    end

    assign bus.sample_tick = sample_tick_p1;
    assign bus.bit_tick    = bit_tick_p1;
    assign bus.mid_tick    = mid_tick_p1;
    assign bus.os_phase    = os_cnt;
    assign bus.cfg_pend    = cfg_pend_q;
    assign bus.cfg_err     = cfg_err_p1;
endmodule
